// File: rtl/matrix_gen_bram.sv
// rtl/matrix_gen_bram.sv - fills a dual-port RAM with a ROWS x COLS column-major matrix
// (PRNG words, secret column, ones column) plus a zero sentinel; registered read port.
module matrix_gen_bram #(
  parameter int WIDTH  = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 3,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] sec_col,
  input  logic              sv_we,
  input  logic [ADDR_W-1:0] sv_idx,
  input  logic [WIDTH-1:0]  sv_data,
  input  logic              rnd_valid,
  input  logic [WIDTH-1:0]  rnd_data,
  output logic              rnd_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_E = ADDR_W'(ROWS * COLS - 1);
  localparam logic [ADDR_W-1:0] SENT_A = ADDR_W'(ROWS * COLS);
  localparam logic [ADDR_W-1:0] LAST_R = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(COLS - 1);

  if (ROWS * COLS + 1 > DEPTH) begin : g_size_check
    $error("matrix_gen_bram: ROWS*COLS+1 exceeds RAM depth");
  end

  typedef enum logic [1:0] {IDLE, FILL, SENT, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] r, c, e;
  logic [ADDR_W-1:0] sec_q;
  logic              sec_en;
  logic [WIDTH-1:0]  secret [ROWS];
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              we, adv, accept, err_n, sv_ok;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata, sec_word;

  assign busy   = (state == FILL) || (state == SENT);
  assign done   = (state == DONE);
  assign accept = start && !busy;
  assign sv_ok  = sv_we && !busy && (sv_idx < ADDR_W'(ROWS));
  assign err_n  = (start && busy) || (accept && sec_col >= LAST_C) ||
                  (sv_we && (busy || sv_idx >= ADDR_W'(ROWS)));

  always_comb begin
    state_n   = state;
    adv       = 1'b0;
    we        = 1'b0;
    waddr     = e;
    wdata     = '0;
    rnd_ready = 1'b0;
    sec_word  = '0;
    for (int i = 0; i < ROWS; i++)
      if (r == ADDR_W'(i)) sec_word = secret[i];
    case (state)
      IDLE, DONE: if (start) state_n = FILL;
      FILL: begin
        if (c == LAST_C) begin
          we = 1'b1; wdata = WIDTH'(1); adv = 1'b1;
        end else if (sec_en && c == sec_q) begin
          we = 1'b1; wdata = sec_word; adv = 1'b1;
        end else begin
          // random entry: stall here until the PRNG presents a word
          rnd_ready = 1'b1;
          if (rnd_valid) begin
            we = 1'b1; wdata = rnd_data; adv = 1'b1;
          end
        end
        if (adv && e == LAST_E) state_n = SENT;
      end
      SENT: begin
        we      = 1'b1;
        waddr   = SENT_A;
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      r        <= '0;
      c        <= '0;
      e        <= '0;
      sec_q    <= '0;
      sec_en   <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      for (int i = 0; i < ROWS; i++) secret[i] <= '0;
    end else begin
      state    <= state_n;
      err      <= err_n;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
      if (accept) begin
        r      <= '0;
        c      <= '0;
        e      <= '0;
        sec_q  <= sec_col;
        sec_en <= (sec_col < LAST_C);
      end else if (adv) begin
        e <= e + 1'b1;
        if (r == LAST_R) begin
          r <= '0;
          c <= c + 1'b1;
        end else begin
          r <= r + 1'b1;
        end
      end
      if (sv_ok)
        for (int i = 0; i < ROWS; i++)
          if (sv_idx == ADDR_W'(i)) secret[i] <= sv_data;
    end
  end

  // write port; nonblocking update gives read-first behaviour on same-address reads
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: doc/matrix_gen_bram.md
# matrix_gen_bram

Parametrised successor to the fixed 4×3 matrix generator. It fills an internal dual-port RAM with a ROWS×COLS matrix in column-major order. Each entry is one of three things: a word from an external PRNG stream, a word from a loadable secret column, or the constant 1 in the last column. A terminating zero word follows the matrix. The block sits between the splitmix PRNG and the matrix-multiply consumer. It adds start/busy/done control, a PRNG valid/ready handshake, a selectable secret column, and registered read access with a valid flag.

## Interface
- WIDTH, 32, data word width
- ROWS, 4, matrix rows (entries per column)
- COLS, 3, matrix columns (≥2); column COLS-1 is the ones column
- ADDR_W, 8, RAM address width; DEPTH = 2^ADDR_W; elaboration fails if ROWS*COLS+1 > DEPTH
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request to (re)generate the matrix
- sec_col  in  ADDR_W  secret column index, sampled with start
- sv_we  in  1  secret-vector register write strobe
- sv_idx  in  ADDR_W  secret-vector row index (0..ROWS-1)
- sv_data  in  WIDTH  secret-vector write data
- rnd_valid  in  1  PRNG word available
- rnd_data  in  WIDTH  PRNG word
- rnd_ready  out  1  block consumes rnd_data this cycle
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  WIDTH  read data, registered
- rd_valid  out  1  rd_data valid (one cycle after rd_en)
- busy  out  1  generation in progress
- done  out  1  matrix complete; held until next accepted start or reset
- err  out  1  one-cycle error pulse

## Operation
- Reset value of every output is 0. Reset clears state, counters, sampled sec_col and the secret-vector registers. RAM contents are not cleared.
- FSM states: IDLE → FILL → SENT → DONE. Any state → IDLE on reset.
- IDLE/DONE with start=1: sample sec_col, clear done, set busy, enter FILL with entry counter e=0 (row r=0, column c=0).
- Start with busy=1: ignored; err pulses.
- FILL writes entry e to address e = c*ROWS + r:
  - c == COLS-1: writes 1.
  - c == sec_col (enabled): writes secret[r].
  - otherwise: writes rnd_data, only on a rnd_valid & rnd_ready cycle.
- rnd_ready = 1 only in FILL when the current entry is random. Deterministic entries write one per cycle without handshake. A random entry with rnd_valid=0 stalls with no write and no advance.
- After entry ROWS*COLS-1: go to SENT. SENT writes 0 to address ROWS*COLS, then enters DONE with busy=0, done=1.
- sec_col ≥ COLS-1 at start: err pulses, the secret column is disabled, and the fill proceeds with random data and the ones column.
- sv_we while busy: write ignored; err pulses. sv_idx ≥ ROWS: write ignored; err pulses. Otherwise secret[sv_idx] ← sv_data.
- Reads are accepted in every state including during reset release. A read of an address written in the same cycle returns the old word (read-first).
- Arithmetic: e, r and c are unsigned counters. r wraps ROWS-1 → 0 with c+1. No other wrap is possible.

## Timing
- start sampled at edge 0. busy=1 after edge 0.
- Entry e is written at the edge on which it advances. With rnd_valid held 1, entries land at edges 1..ROWS*COLS and the sentinel at edge ROWS*COLS+1. Defaults: writes at edges 1..12, sentinel at 13, busy=0/done=1 after edge 13.
- Each stalled random entry adds one edge to all later events.
- rd_valid and rd_data appear one cycle after rd_en. rd_valid=0 otherwise. rd_data holds its last value.
- Reset asserted mid-fill: outputs go to 0 immediately (asynchronous). Partial RAM contents remain. A later start refills from e=0.

## Test plan
- Defaults; secret={1,2,3,4}; sec_col=1; counting PRNG 0xA0,0xA1,… with rnd_valid=1 → mem[0..3]=A0..A3, mem[4..7]=1..4, mem[8..11]=1, mem[12]=0; done after edge 13; exactly 4 rnd handshakes.
- Same setup with rnd_valid=0 for 5 cycles during entry 2 → identical contents; done after edge 18; rnd_ready high throughout the stall.
- sec_col=2 → err pulse at edge 1; mem[0..7]=A0..A7, mem[8..11]=1, mem[12]=0; 8 handshakes.
- reset pulse at edge 6 → busy=done=rnd_ready=0 immediately; new start → full correct refill, done 13 edges later.
- start and sv_we issued while busy → one err pulse each; no restart; secret register unchanged; fill result unchanged.
- rd_en at addr 5 after done → rd_valid=1 and rd_data=2 one cycle later; back-to-back reads at 12 and 0 → 0 then A0 on consecutive cycles.
